psmac_seq_ctrl: RTL

Job sequencer for one precision-scalable MAC array (2b/4b/8b modes). It accepts a dot-product job descriptor and streams packed input/weight beats into the MAC. It drives mode and per-slice sign controls, accumulates the MAC's registered 16-bit output over the job length, and returns the sum through a valid/ready result port. It sits between the operand buffers and the MAC instance.

---
 rtl/psmac_seq_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/psmac_seq_ctrl.sv
// Job sequencer for a precision-scalable MAC array.
// Ports: cfg_* job in, op_* beats in, mac_* drive, res_* sum out, busy_o.
module psmac_seq_ctrl #(
  parameter int          ACC_W   = 32,
  parameter int          LEN_W   = 16,
  parameter int          MAC_LAT = 1,
  parameter logic [15:0] SXM_2B  = 16'hFFFF,
  parameter logic [15:0] SYM_2B  = 16'hFFFF,
  parameter logic [15:0] SXM_4B  = 16'h8888,
  parameter logic [15:0] SYM_4B  = 16'h8888,
  parameter logic [15:0] SXM_8B  = 16'h8000,
  parameter logic [15:0] SYM_8B  = 16'h8000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_prec_i,
  input  logic             cfg_signed_ip_i,
  input  logic             cfg_signed_wt_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_ip_i,
  input  logic [31:0]      op_wt_i,
  output logic [31:0]      mac_ip_o,
  output logic [31:0]      mac_wt_o,
  output logic [3:0]       mac_sx1_o,
  output logic [3:0]       mac_sx2_o,
  output logic [3:0]       mac_sx3_o,
  output logic [3:0]       mac_sx4_o,
  output logic [3:0]       mac_sy1_o,
  output logic [3:0]       mac_sy2_o,
  output logic [3:0]       mac_sy3_o,
  output logic [3:0]       mac_sy4_o,
  output logic             mac_mode1_o,
  output logic             mac_mode2_o,
  input  logic [15:0]      mac_y_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic             res_ovf_o,
  output logic             res_err_o,
  output logic             busy_o
);

  localparam int PD = MAC_LAT + 1;
  localparam logic [PD-1:0] VP_LAST = PD'(1) << MAC_LAT;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_RES
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [1:0]       prec_q, prec_d;
  logic             sip_q, sip_d;
  logic             swt_q, swt_d;
  logic [31:0]      mip_q, mip_d;
  logic [31:0]      mwt_q, mwt_d;
  logic [PD-1:0]    vp_q, vp_d;

  logic             cfg_hs, op_hs, active;
  logic [ACC_W-1:0] y_ext, sum;
  logic [15:0]      sxm, sym, sx, sy;

  assign cfg_ready_o = (state_q == S_IDLE) & rst_ni;
  assign op_ready_o  = (state_q == S_RUN);
  assign res_valid_o = (state_q == S_RES);
  assign busy_o      = (state_q != S_IDLE);
  assign cfg_hs      = cfg_valid_i & cfg_ready_o;
  assign op_hs       = op_valid_i & op_ready_o;

  assign y_ext = {{(ACC_W-16){mac_y_i[15]}}, mac_y_i};
  assign sum   = acc_q + y_ext;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    prec_d  = prec_q;
    sip_d   = sip_q;
    swt_d   = swt_q;
    mip_d   = '0;
    mwt_d   = '0;
    vp_d    = vp_q << 1;
    // A 1 leaving the pipe marks mac_y as the result of a real beat.
    if (vp_q[PD-1]) begin
      acc_d = sum;
      if (acc_q[ACC_W-1] == y_ext[ACC_W-1] &&
          sum[ACC_W-1] != acc_q[ACC_W-1])
        ovf_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          prec_d = cfg_prec_i;
          sip_d  = cfg_signed_ip_i;
          swt_d  = cfg_signed_wt_i;
          acc_d  = '0;
          ovf_d  = 1'b0;
          err_d  = (cfg_prec_i == 2'd3);
          cnt_d  = cfg_len_i;
          if (cfg_prec_i == 2'd3 || cfg_len_i == '0) begin
            cnt_d   = '0;
            state_d = S_RES;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_hs) begin
          mip_d   = op_ip_i;
          mwt_d   = op_wt_i;
          vp_d[0] = 1'b1;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vp_q == VP_LAST)
          state_d = S_RES;
      end
      S_RES: begin
        if (res_ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      prec_q  <= '0;
      sip_q   <= 1'b0;
      swt_q   <= 1'b0;
      mip_q   <= '0;
      mwt_q   <= '0;
      vp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      prec_q  <= prec_d;
      sip_q   <= sip_d;
      swt_q   <= swt_d;
      mip_q   <= mip_d;
      mwt_q   <= mwt_d;
      vp_q    <= vp_d;
    end
  end

  // Mode and sign controls only apply while a valid job is held.
  assign active = (state_q != S_IDLE) && (prec_q != 2'd3);

  always_comb begin
    sxm = '0;
    sym = '0;
    unique case (prec_q)
      2'd0: begin sxm = SXM_2B; sym = SYM_2B; end
      2'd1: begin sxm = SXM_4B; sym = SYM_4B; end
      2'd2: begin sxm = SXM_8B; sym = SYM_8B; end
      default: begin sxm = '0; sym = '0; end
    endcase
  end

  assign sx = (active && sip_q) ? sxm : '0;
  assign sy = (active && swt_q) ? sym : '0;
  assign {mac_sx4_o, mac_sx3_o, mac_sx2_o, mac_sx1_o} = sx;
  assign {mac_sy4_o, mac_sy3_o, mac_sy2_o, mac_sy1_o} = sy;

  assign mac_mode1_o = active && (prec_q != 2'd0);
  assign mac_mode2_o = active && (prec_q == 2'd2);

  assign mac_ip_o   = mip_q;
  assign mac_wt_o   = mwt_q;
  assign res_data_o = acc_q;
  assign res_ovf_o  = ovf_q;
  assign res_err_o  = err_q;

endmodule
